// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-3 slave with RX/TX byte FIFOs and sticky status
module spi_slave_responder #(
    parameter int         RX_DEPTH  = 16,
    parameter int         TX_DEPTH  = 16,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       cs_active,
    output logic [7:0] byte_count,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       status_clr
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DESEL} state_t;

    state_t state, state_next;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic csn_s1, csn_s2, csn_s3;
    logic mosi_s1, mosi_s2;

    logic sclk_fall, sclk_rise, csn_fall, csn_rise;
    logic start, bit_fall, bit_rise;
    logic tx_load, tx_pop, underrun_set, rx_push;

    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_full, rx_empty, rx_pop, rx_wr, overrun_set;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_full, tx_empty, tx_wr;

    // Pin synchronizers; left unreset so they always track the real pin levels
    always_ff @(posedge clk) begin
        sclk_s1 <= spi_clk;
        sclk_s2 <= sclk_s1;
        sclk_s3 <= sclk_s2;
        csn_s1  <= spi_csn;
        csn_s2  <= csn_s1;
        csn_s3  <= csn_s2;
        mosi_s1 <= spi_mosi;
        mosi_s2 <= mosi_s1;
    end

    assign sclk_fall = sclk_s3 & ~sclk_s2;
    assign sclk_rise = ~sclk_s3 & sclk_s2;
    assign csn_fall  = csn_s3 & ~csn_s2;
    assign csn_rise  = ~csn_s3 & csn_s2;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_DESEL;
        else       state <= state_next;
    end

    // Next-state and per-cycle bit strobes; deselect beats any same-cycle sclk edge
    always_comb begin
        state_next = state;
        start      = 1'b0;
        bit_fall   = 1'b0;
        bit_rise   = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_rise) begin
                    state_next = IDLE;
                end else begin
                    bit_fall = sclk_fall;
                    bit_rise = sclk_rise;
                end
            end
            WAIT_DESEL: begin
                if (csn_s2) state_next = IDLE;
            end
            default: state_next = WAIT_DESEL;
        endcase
    end

    assign tx_load      = bit_fall && (bit_cnt == 3'd0);
    assign tx_pop       = tx_load && !tx_empty;
    assign underrun_set = tx_load && tx_empty;
    assign rx_push      = bit_rise && (bit_cnt == 3'd7);
    assign rx_byte      = {rx_shift, mosi_s2};

    // Bit/byte counters and the two shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            byte_count <= 8'd0;
            tx_shift   <= 8'd0;
            rx_shift   <= 7'd0;
        end else if (start) begin
            bit_cnt    <= 3'd0;
            byte_count <= 8'd0;
        end else begin
            if (tx_load)
                tx_shift <= tx_empty ? FILL_BYTE : tx_mem[tx_rd_ptr];
            else if (bit_fall)
                tx_shift <= {tx_shift[6:0], 1'b0};
            if (bit_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_s2};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (rx_push && byte_count != 8'hFF)
                byte_count <= byte_count + 8'd1;
        end
    end

    assign rx_full     = (rx_count == (RX_AW+1)'(RX_DEPTH));
    assign rx_empty    = (rx_count == '0);
    assign rx_valid    = !rx_empty;
    assign rx_data     = rx_mem[rx_rd_ptr];
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_wr       = rx_push && (!rx_full || rx_pop);
    assign overrun_set = rx_push && rx_full && !rx_pop;

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wr_ptr] <= rx_byte;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_wr)  rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_wr && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_wr && rx_pop) rx_count <= rx_count - 1'b1;
        end
    end

    assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_ready = !tx_full;
    assign tx_wr    = tx_valid && tx_ready;

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wr_ptr] <= tx_data;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_wr)  tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_wr && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_wr && tx_pop) tx_count <= tx_count - 1'b1;
        end
    end

    // Sticky error flags; a new event outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (overrun_set)     rx_overrun <= 1'b1;
            else if (status_clr) rx_overrun <= 1'b0;
            if (underrun_set)    tx_underrun <= 1'b1;
            else if (status_clr) tx_underrun <= 1'b0;
        end
    end

    assign cs_active   = (state == ACTIVE);
    assign spi_miso_oe = cs_active;
    assign spi_miso    = cs_active ? tx_shift[7] : 1'b1;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed bench for spi_slave_responder
module tb_spi_slave_responder;

    logic       clk;
    logic       reset;
    logic       spi_clk, spi_csn, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       cs_active;
    logic [7:0] byte_count;
    logic       rx_overrun, tx_underrun, status_clr;

    int checks = 0;
    int errors = 0;
    logic [7:0] mi;
    bit         wr_seen;

    typedef struct {
        logic       preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic       exp_underrun;
    } vec_t;

    vec_t vecs[4];

    spi_slave_responder #(.RX_DEPTH(16), .TX_DEPTH(16), .FILL_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cs_active(cs_active), .byte_count(byte_count),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .status_clr(status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        wait_clk(1);
        status_clr = 1'b0;
    endtask

    task automatic spi_begin();
        spi_csn = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_end();
        wait_clk(8);
        spi_csn = 1'b1;
        wait_clk(8);
    endtask

    // Mode 3 master, half-period 8 clk: drive MOSI at falling sclk, sample MISO at rising sclk
    task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = mo[i];
            wait_clk(8);
            spi_clk  = 1'b1;
            got[i]   = spi_miso;
            wait_clk(8);
        end
    endtask

    task automatic rx_expect(input string name, input logic [7:0] exp);
        check({name, "_valid"}, rx_valid, 1'b1);
        check({name, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; spi_clk = 1'b1; spi_csn = 1'b1; spi_mosi = 1'b0;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; status_clr = 1'b0;

        vecs[0] = '{1'b1, 8'hA5, 8'h9F, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 8'h00, 8'h3C, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'h81, 8'hC3, 8'h81, 1'b0};

        wait_clk(4);
        do_reset();

        check("rst_miso", spi_miso, 1'b1);
        check("rst_miso_oe", spi_miso_oe, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_cs_active", cs_active, 1'b0);
        check("rst_byte_count", byte_count, 8'd0);
        check("rst_flags", {rx_overrun, tx_underrun}, 2'b00);

        // Single-byte selects from the vector table
        for (int i = 0; i < 4; i++) begin
            clear_status();
            if (vecs[i].preload) push_tx(vecs[i].tx);
            spi_begin();
            check($sformatf("vec%0d_cs_active", i), cs_active, 1'b1);
            spi_byte(vecs[i].mosi, 8, mi);
            spi_end();
            check($sformatf("vec%0d_miso", i), mi, vecs[i].exp_miso);
            check($sformatf("vec%0d_byte_count", i), byte_count, 8'd1);
            check($sformatf("vec%0d_underrun", i), tx_underrun, vecs[i].exp_underrun);
            rx_expect($sformatf("vec%0d_rx", i), vecs[i].mosi);
        end
        clear_status();
        check("underrun_cleared", tx_underrun, 1'b0);

        // Two bytes in one select
        do_reset();
        push_tx(8'hA5);
        push_tx(8'h3C);
        spi_begin();
        spi_byte(8'h9F, 8, mi);
        check("two_miso0", mi, 8'hA5);
        spi_byte(8'h00, 8, mi);
        check("two_miso1", mi, 8'h3C);
        spi_end();
        check("two_byte_count", byte_count, 8'd2);
        rx_expect("two_rx0", 8'h9F);
        rx_expect("two_rx1", 8'h00);
        check("two_rx_empty", rx_valid, 1'b0);

        // RX overrun: 17 bytes into a 16-deep FIFO with no draining
        do_reset();
        spi_begin();
        for (int i = 0; i < 17; i++) spi_byte(8'h10 + 8'(i), 8, mi);
        spi_end();
        check("ovr_flag", rx_overrun, 1'b1);
        check("ovr_byte_count", byte_count, 8'd17);
        for (int i = 0; i < 16; i++) rx_expect($sformatf("ovr_rx%0d", i), 8'h10 + 8'(i));
        check("ovr_rx_empty", rx_valid, 1'b0);

        // Deselect after 5 bits: partial byte discarded, next select uses next TX byte
        do_reset();
        push_tx(8'hC1);
        push_tx(8'hD2);
        spi_begin();
        spi_byte(8'h55, 5, mi);
        spi_end();
        check("part_miso_bits", mi[7:3], 5'b11000);
        check("part_no_rx", rx_valid, 1'b0);
        spi_begin();
        spi_byte(8'h77, 8, mi);
        spi_end();
        check("part_next_miso", mi, 8'hD2);
        rx_expect("part_next_rx", 8'h77);

        // Reset mid-byte with csn held low: slave stays out until csn toggles
        do_reset();
        spi_begin();
        spi_byte(8'hAB, 3, mi);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(2);
        check("mrst_cs_active", cs_active, 1'b0);
        check("mrst_miso", {spi_miso, spi_miso_oe}, 2'b10);
        spi_byte(8'h5C, 8, mi);
        wait_clk(8);
        check("mrst_no_rx", rx_valid, 1'b0);
        check("mrst_still_out", cs_active, 1'b0);
        spi_end();
        spi_begin();
        spi_byte(8'h3A, 8, mi);
        spi_end();
        rx_expect("mrst_rx_after", 8'h3A);

        // TX full: held write lands as soon as the SPI pop frees a slot
        do_reset();
        for (int i = 0; i < 16; i++) push_tx(8'h40 + 8'(i));
        check("txf_full_ready", tx_ready, 1'b0);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        wr_seen  = 1'b0;
        spi_begin();
        fork
            begin
                spi_byte(8'h00, 8, mi);
            end
            begin
                for (int k = 0; k < 300 && !wr_seen; k++) begin
                    wait_clk(1);
                    if (tx_ready) wr_seen = 1'b1;
                end
                check("txf_write_window", wr_seen, 1'b1);
                wait_clk(1);
                tx_valid = 1'b0;
                check("txf_ready_after_write", tx_ready, 1'b0);
            end
        join
        check("txf_miso0", mi, 8'h40);
        for (int i = 1; i < 16; i++) begin
            spi_byte(8'h00, 8, mi);
            check($sformatf("txf_miso%0d", i), mi, 8'h40 + 8'(i));
        end
        spi_byte(8'h00, 8, mi);
        check("txf_miso_new", mi, 8'hEE);
        spi_end();
        check("txf_no_underrun", tx_underrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
